cpu_core: RTL and testbench
===========================

Name: cpu_core

Overview:
- Parametrised multi-cycle 16-register CPU core: sequencer, register file and ALU in one block.
- Talks to external memory over a single request/ready port, so slow memories insert wait states instead of the core relying on a fixed-latency bus.
- Adds halt, illegal-opcode trap, instruction-boundary hold and a retired-instruction counter.
- Sits under the board top-level, next to the memory model.

Parameters:
- DATA_W, 16, register/data width; must be >=16; instruction occupies bits [15:0] of the fetched word.
- ADDR_W, 16, memory address and PC width.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- hold  input  1  high: core parks in IDLE at the next instruction boundary.
- memAddr  output  ADDR_W  memory address.
- memRe  output  1  read request.
- memWe  output  1  write request.
- memWData  output  DATA_W  store data.
- memRData  input  DATA_W  load/fetch data, valid when memReady=1.
- memReady  input  1  transfer completes on an edge where a request and memReady are both high.
- pc  output  ADDR_W  current PC.
- halted  output  1  core stopped.
- illegal  output  1  stop was caused by an illegal opcode.
- retired  output  32  retired-instruction count.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_PC, r1..r15=0, retired=0.
  - halted=0, illegal=0, memRe=0, memWe=0, memAddr=RESET_PC, memWData=0.
- Instruction format: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm8=[7:0].
- r0 always reads 0; writes to r0 are discarded.
- States:
  - IDLE -> FETCH when hold=0, else stay.
  - FETCH: memRe=1, memAddr=pc. Stay until memReady=1; then latch instruction, pc<=pc+1 (mod 2^ADDR_W), go to EXEC.
  - EXEC: execute the instruction. LD/ST -> MEM. HLT or illegal -> HALTED. Otherwise retire, then go to FETCH, or to IDLE if hold=1.
  - MEM: LD drives memRe=1, memAddr=rs[ADDR_W-1:0] (zero-extended if ADDR_W>DATA_W). ST drives memWe=1 with the same address, memWData=rd. Stay until memReady=1; then LD writes memRData to rd. Retire, then FETCH or IDLE per hold.
  - HALTED: absorbing. halted=1, no memory requests. Leaves only on reset.
- Request stability: memAddr, memWData, memRe and memWe stay constant while waiting. memRe and memWe are never both high.
- memReady while no request is pending is ignored.
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs+rt.
  - 2 SUB rd=rs-rt.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SHL rd=rs<<1.
  - 7 SHR rd=rs>>1 (logical).
  - 8 LDI rd=zero-extended imm8.
  - 9 LD rd=mem[rs].
  - A ST mem[rs]=rd.
  - B JMP pc=rs.
  - C BZ: if rd==0 then pc=rs.
  - D, E illegal.
  - F HLT.
- Arithmetic: all results wrap modulo 2^DATA_W; no flags.
- Register writes commit on the edge that leaves EXEC (ALU ops, LDI) or MEM (LD).
- Branch/jump targets are rs truncated to ADDR_W and overwrite the incremented pc in EXEC.
- Latency with memReady tied high: ALU/LDI/JMP/BZ/NOP = 2 cycles; LD/ST = 3 cycles. Each memReady-low cycle adds 1.
- retired increments by 1 per completed instruction, including NOP, wraps at 2^32. HLT and illegal do not count.
- HLT sets halted=1 on the edge leaving EXEC. Illegal sets halted=1 and illegal=1 on the same edge.
- hold is sampled only in IDLE and at instruction completion. It never aborts a memory request in progress.
- Reset mid-request drops memRe/memWe immediately (async). No register write from the aborted instruction.

Test Plan:
- Reset check: release rst with memReady=1, mem[0]=0x8105 (LDI r1,5), mem[1]=0xF000 -> memRe=0 during reset; r1=5 after 2 cycles; halted=1; retired=1; pc=2.
- Arithmetic wrap: r1=0xFFFF, r2=0x0002, ADD r3,r1,r2 -> r3=0x0001. SUB r4,r2,r1 -> r4=0x0003. Write to r0 -> r0 still reads 0.
- Wait states: memReady low for 3 cycles on the fetch of LD r5,[r1] with mem[r1]=0xBEEF -> memAddr/memRe stable throughout; r5=0xBEEF; total instruction 6 cycles.
- Store and branch: ST r5,[r6] writes 0xBEEF to address r6 with memWe=1 for exactly 1 cycle (memReady=1). BZ with r0 condition to target 0x0010 -> next fetch address 0x0010.
- Hold and illegal: hold=1 during ADD -> ADD completes, core parks in IDLE with no requests; hold=0 resumes fetch at the next pc. Opcode 0xD000 -> halted=1, illegal=1, retired unchanged.
- Async reset mid-MEM of a ST with memReady=0 -> memWe falls without a clock edge; after release pc=RESET_PC, registers=0.

Source files
------------

// File: rtl/cpu_core.sv
// Multi-cycle 16-register CPU core: sequencer, register file and ALU sharing a
// single request/ready memory port, with halt, illegal trap, hold and retire count.
module cpu_core #(
  parameter int unsigned         DATA_W   = 16,
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRe,
  output logic              memWe,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memReady,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       retired
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALTED} state_e;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_LDI = 4'h8, OP_LD  = 4'h9, OP_ST  = 4'hA, OP_JMP = 4'hB,
    OP_BZ  = 4'hC, OP_HLT = 4'hF
  } op_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [31:0]         retired_q, retired_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;
  logic [DATA_W-1:0]   regs_q [16];

  logic                rf_we;
  logic [3:0]          rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  op_e                 op;
  logic [3:0]          rd, rs, rt;
  logic [DATA_W-1:0]   rd_val, rs_val, rt_val, alu_res;
  logic [ADDR_W-1:0]   rs_addr;

  assign op     = op_e'(ir_q[15:12]);
  assign rd     = ir_q[11:8];
  assign rs     = ir_q[7:4];
  assign rt     = ir_q[3:0];
  assign rd_val = (rd == 4'd0) ? '0 : regs_q[rd];
  assign rs_val = (rs == 4'd0) ? '0 : regs_q[rs];
  assign rt_val = (rt == 4'd0) ? '0 : regs_q[rt];

  generate
    if (ADDR_W <= DATA_W) begin : g_addr_trunc
      assign rs_addr = rs_val[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign rs_addr = {{(ADDR_W-DATA_W){1'b0}}, rs_val};
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = rs_val + rt_val;
      OP_SUB:  alu_res = rs_val - rt_val;
      OP_AND:  alu_res = rs_val & rt_val;
      OP_OR:   alu_res = rs_val | rt_val;
      OP_XOR:  alu_res = rs_val ^ rt_val;
      OP_SHL:  alu_res = {rs_val[DATA_W-2:0], 1'b0};
      OP_SHR:  alu_res = {1'b0, rs_val[DATA_W-1:1]};
      OP_LDI:  alu_res = DATA_W'(ir_q[7:0]);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_waddr  = rd;
    rf_wdata  = alu_res;
    memRe     = 1'b0;
    memWe     = 1'b0;
    memAddr   = pc_q;
    memWData  = '0;
    case (state_q)
      S_IDLE: if (!hold) state_d = S_FETCH;
      S_FETCH: begin
        memRe = 1'b1;
        if (memReady) begin
          ir_d    = memRData[15:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_LD, OP_ST: state_d = S_MEM;
          OP_HLT: begin
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end
          OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
          OP_LDI, OP_JMP, OP_BZ: begin
            rf_we = (op != OP_NOP) && (op != OP_JMP) && (op != OP_BZ);
            if (op == OP_JMP || (op == OP_BZ && rd_val == '0)) pc_d = rs_addr;
            retired_d = retired_q + 32'd1;
            state_d   = hold ? S_IDLE : S_FETCH;
          end
          default: begin
            halted_d  = 1'b1;
            illegal_d = 1'b1;
            state_d   = S_HALTED;
          end
        endcase
      end
      S_MEM: begin
        // Address and data come straight from registers that cannot change until completion.
        memAddr = rs_addr;
        if (op == OP_LD) memRe = 1'b1;
        else begin
          memWe    = 1'b1;
          memWData = rd_val;
        end
        if (memReady) begin
          rf_we     = (op == OP_LD);
          rf_wdata  = memRData;
          retired_d = retired_q + 32'd1;
          state_d   = hold ? S_IDLE : S_FETCH;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      if (rf_we && rf_waddr != 4'd0) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign pc      = pc_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core with a word-addressed memory model.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic        memReady = 1'b1;
  logic [15:0] memAddr, memWData, memRData, pc;
  logic        memRe, memWe, halted, illegal;
  logic [31:0] retired;

  logic [15:0] mem [0:65535];
  int checks = 0;
  int errors = 0;
  int st_count = 0;
  int we_hi = 0;
  logic [15:0] st_addr = '0;
  logic [15:0] st_data = '0;

  cpu_core #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .memAddr(memAddr), .memRe(memRe), .memWe(memWe), .memWData(memWData),
    .memRData(memRData), .memReady(memReady),
    .pc(pc), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  assign memRData = mem[memAddr];

  always @(posedge clk) begin
    if (memWe) we_hi++;
    if (memWe && memReady) begin
      st_count++;
      st_addr <= memAddr;
      st_data <= memWData;
    end
  end

  task automatic start_reset();
    rst = 1'b0;
    hold = 1'b0;
    memReady = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_halt(input int max, output int cyc);
    cyc = 0;
    while (!halted && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    start_reset();
    mem[0] = 16'h8105;
    mem[1] = 16'hF000;
    @(negedge clk);
    checks++; if (memRe !== 1'b0 || memWe !== 1'b0) begin errors++; $display("FAIL rst_req: re=%b we=%b expected 0 0", memRe, memWe); end
    checks++; if (pc !== 16'h0000 || memAddr !== 16'h0000) begin errors++; $display("FAIL rst_pc: pc=%h addr=%h expected 0000", pc, memAddr); end
    checks++; if (halted !== 1'b0 || illegal !== 1'b0 || retired !== 32'd0) begin errors++; $display("FAIL rst_status: h=%b i=%b ret=%0d expected 0 0 0", halted, illegal, retired); end
    release_reset();
    repeat (3) @(negedge clk);
    checks++; if (dut.regs_q[1] !== 16'h0005 || retired !== 32'd1) begin errors++; $display("FAIL rst_ldi: r1=%h ret=%0d expected 0005 1", dut.regs_q[1], retired); end
    repeat (2) @(negedge clk);
    checks++; if (halted !== 1'b1 || pc !== 16'h0002 || retired !== 32'd1 || memRe !== 1'b0) begin errors++; $display("FAIL rst_hlt: h=%b pc=%h ret=%0d re=%b expected 1 0002 1 0", halted, pc, retired, memRe); end
  endtask

  task automatic test_arith();
    int cyc;
    logic [15:0] prog [13] = '{16'h8201, 16'h2102, 16'h8202, 16'h1312, 16'h2421, 16'h8077, 16'h1501,
                               16'h3612, 16'h4723, 16'h5812, 16'h6910, 16'h7A10, 16'hF000};
    logic [15:0] exp_r [11] = '{16'h0000, 16'hFFFF, 16'h0002, 16'h0001, 16'h0003, 16'hFFFF,
                                16'h0002, 16'h0003, 16'hFFFD, 16'hFFFE, 16'h7FFF};
    start_reset();
    for (int i = 0; i < 13; i++) mem[i] = prog[i];
    release_reset();
    wait_halt(200, cyc);
    checks++; if (halted !== 1'b1 || cyc !== 27) begin errors++; $display("FAIL arith_cycles: halted=%b cycles=%0d expected 1 27", halted, cyc); end
    for (int r = 0; r < 11; r++) begin
      checks++;
      if (dut.regs_q[r] !== exp_r[r]) begin errors++; $display("FAIL arith_r%0d: got %h expected %h", r, dut.regs_q[r], exp_r[r]); end
    end
    checks++; if (retired !== 32'd12 || illegal !== 1'b0) begin errors++; $display("FAIL arith_retired: ret=%0d ill=%b expected 12 0", retired, illegal); end
  endtask

  task automatic test_wait_states();
    int cyc;
    start_reset();
    mem[0] = 16'h8140;
    mem[1] = 16'h9510;
    mem[2] = 16'hF000;
    mem[16'h40] = 16'hBEEF;
    release_reset();
    repeat (2) @(negedge clk);
    memReady = 1'b0;
    @(negedge clk);
    checks++; if (memRe !== 1'b1 || memAddr !== 16'h0001) begin errors++; $display("FAIL ws_fetch_start: re=%b addr=%h expected 1 0001", memRe, memAddr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (memRe !== 1'b1 || memWe !== 1'b0 || memAddr !== 16'h0001) begin errors++; $display("FAIL ws_stable%0d: re=%b we=%b addr=%h expected 1 0 0001", i, memRe, memWe, memAddr); end
    end
    memReady = 1'b1;
    @(negedge clk);
    checks++; if (memRe !== 1'b0 || pc !== 16'h0002) begin errors++; $display("FAIL ws_exec: re=%b pc=%h expected 0 0002", memRe, pc); end
    @(negedge clk);
    checks++; if (memRe !== 1'b1 || memAddr !== 16'h0040 || retired !== 32'd1) begin errors++; $display("FAIL ws_mem: re=%b addr=%h ret=%0d expected 1 0040 1", memRe, memAddr, retired); end
    @(negedge clk);
    checks++; if (dut.regs_q[5] !== 16'hBEEF || retired !== 32'd2) begin errors++; $display("FAIL ws_load: r5=%h ret=%0d expected beef 2", dut.regs_q[5], retired); end
    wait_halt(20, cyc);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ws_halt_timeout: halted=%b expected 1", halted); end
  endtask

  task automatic test_store_branch();
    int cyc, we0, st0;
    logic [15:0] prog [10] = '{16'h8140, 16'h9510, 16'h8650, 16'hA560, 16'h8901,
                               16'h8720, 16'hC970, 16'h8710, 16'hC070, 16'hF000};
    start_reset();
    for (int i = 0; i < 10; i++) mem[i] = prog[i];
    mem[16'h10] = 16'h8801;
    mem[16'h11] = 16'hF000;
    mem[16'h40] = 16'hBEEF;
    we0 = we_hi;
    st0 = st_count;
    release_reset();
    wait_halt(200, cyc);
    checks++; if (halted !== 1'b1 || cyc !== 25) begin errors++; $display("FAIL sb_cycles: halted=%b cycles=%0d expected 1 25", halted, cyc); end
    checks++; if (we_hi - we0 !== 1 || st_count - st0 !== 1) begin errors++; $display("FAIL sb_we_pulse: we_cycles=%0d stores=%0d expected 1 1", we_hi - we0, st_count - st0); end
    checks++; if (st_addr !== 16'h0050 || st_data !== 16'hBEEF) begin errors++; $display("FAIL sb_store: addr=%h data=%h expected 0050 beef", st_addr, st_data); end
    checks++; if (dut.regs_q[8] !== 16'h0001 || dut.regs_q[7] !== 16'h0010) begin errors++; $display("FAIL sb_branch_regs: r8=%h r7=%h expected 0001 0010", dut.regs_q[8], dut.regs_q[7]); end
    checks++; if (pc !== 16'h0012 || retired !== 32'd10 || illegal !== 1'b0) begin errors++; $display("FAIL sb_final: pc=%h ret=%0d ill=%b expected 0012 10 0", pc, retired, illegal); end
  endtask

  task automatic test_hold_illegal();
    int cyc;
    start_reset();
    mem[0] = 16'h8103;
    mem[1] = 16'h8204;
    mem[2] = 16'h1312;
    mem[3] = 16'h8401;
    mem[4] = 16'hD000;
    release_reset();
    repeat (6) @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    checks++; if (dut.regs_q[3] !== 16'h0007 || retired !== 32'd3 || pc !== 16'h0003) begin errors++; $display("FAIL hold_add: r3=%h ret=%0d pc=%h expected 0007 3 0003", dut.regs_q[3], retired, pc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (memRe !== 1'b0 || memWe !== 1'b0 || pc !== 16'h0003) begin errors++; $display("FAIL hold_park%0d: re=%b we=%b pc=%h expected 0 0 0003", i, memRe, memWe, pc); end
    end
    hold = 1'b0;
    @(negedge clk);
    checks++; if (memRe !== 1'b1 || memAddr !== 16'h0003) begin errors++; $display("FAIL hold_resume: re=%b addr=%h expected 1 0003", memRe, memAddr); end
    wait_halt(50, cyc);
    checks++; if (halted !== 1'b1 || illegal !== 1'b1) begin errors++; $display("FAIL illegal_flags: h=%b i=%b expected 1 1", halted, illegal); end
    checks++; if (retired !== 32'd4 || dut.regs_q[4] !== 16'h0001 || pc !== 16'h0005) begin errors++; $display("FAIL illegal_state: ret=%0d r4=%h pc=%h expected 4 0001 0005", retired, dut.regs_q[4], pc); end
    repeat (3) @(negedge clk);
    checks++; if (memRe !== 1'b0 || memWe !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halted_absorb: re=%b we=%b h=%b expected 0 0 1", memRe, memWe, halted); end
  endtask

  task automatic test_async_reset();
    int st0;
    start_reset();
    mem[0] = 16'h8140;
    mem[1] = 16'h8233;
    mem[2] = 16'hA210;
    release_reset();
    repeat (6) @(negedge clk);
    memReady = 1'b0;
    @(negedge clk);
    checks++; if (memWe !== 1'b1 || memRe !== 1'b0 || memAddr !== 16'h0040 || memWData !== 16'h0033) begin errors++; $display("FAIL ar_store_req: we=%b re=%b addr=%h data=%h expected 1 0 0040 0033", memWe, memRe, memAddr, memWData); end
    @(negedge clk);
    checks++; if (memWe !== 1'b1 || memAddr !== 16'h0040 || memWData !== 16'h0033) begin errors++; $display("FAIL ar_store_stable: we=%b addr=%h data=%h expected 1 0040 0033", memWe, memAddr, memWData); end
    st0 = st_count;
    #2 rst = 1'b0;
    #1;
    checks++; if (memWe !== 1'b0 || memRe !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL ar_async_drop: we=%b re=%b pc=%h expected 0 0 0000", memWe, memRe, pc); end
    @(negedge clk);
    memReady = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (dut.regs_q[1] !== 16'h0000 || dut.regs_q[2] !== 16'h0000 || retired !== 32'd0) begin errors++; $display("FAIL ar_regs: r1=%h r2=%h ret=%0d expected 0000 0000 0", dut.regs_q[1], dut.regs_q[2], retired); end
    checks++; if (st_count !== st0 || pc !== 16'h0000) begin errors++; $display("FAIL ar_no_store: stores=%0d pc=%h expected %0d 0000", st_count, pc, st0); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_wait_states();
    test_store_branch();
    test_hold_illegal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
